munoc_control_axi_frontend: RTL
===============================

Name:
munoc_control_axi_frontend

Overview:
AXI4 slave front end for the MUNOC control/info/error-log register block. It converts AXI write and read bursts into single-word register requests, one beat at a time, using the downstream's valid/ready-pulse/error protocol. It returns B and R responses, with SLVERR when the register block flags an unmapped access.

Parameters:
BW_ADDR, 32, AXI and request address width
BW_DATA, 32, AXI and register data width; address step per beat = BW_DATA/8
BW_AXI_TID, 4, AXI ID width
BW_MASTER_NODE_ID, 4, master node ID width; taken from the upper bits of the AXI ID (BW_MASTER_NODE_ID <= BW_AXI_TID)

Ports:
clk  in  1  clock
rstnn  in  1  asynchronous active-low reset
sxawid  in  BW_AXI_TID  write address ID
sxawaddr  in  BW_ADDR  write start address
sxawlen  in  8  write beats minus 1
sxawvalid  in  1  AW valid
sxawready  out  1  AW ready
sxwdata  in  BW_DATA  write data
sxwvalid  in  1  W valid
sxwready  out  1  W ready
sxbid  out  BW_AXI_TID  B ID
sxbresp  out  2  00 OKAY / 10 SLVERR
sxbvalid  out  1  B valid
sxbready  in  1  B ready
sxarid  in  BW_AXI_TID  read address ID
sxaraddr  in  BW_ADDR  read start address
sxarlen  in  8  read beats minus 1
sxarvalid  in  1  AR valid
sxarready  out  1  AR ready
sxrid  out  BW_AXI_TID  R ID
sxrdata  out  BW_DATA  read data
sxrresp  out  2  00 OKAY / 10 SLVERR
sxrlast  out  1  last read beat
sxrvalid  out  1  R valid
sxrready  in  1  R ready
req_valid  out  1  register request; held until req_ready
req_addr  out  BW_ADDR  current beat address
req_write  out  1  1 = write, 0 = read
req_wdata  out  BW_DATA  write data for current beat
req_master_id  out  BW_MASTER_NODE_ID  requesting master = sxawid/sxarid[BW_AXI_TID-1 -: BW_MASTER_NODE_ID]
req_ready  in  1  one-cycle completion pulse; req_rdata and req_error are valid in the same cycle
req_rdata  in  BW_DATA  read data
req_error  in  1  unmapped-access flag

Behaviour:
- Reset: all outputs 0, FSM=IDLE, priority favours write. Reset mid-burst abandons the transaction; no response is issued.
- FSM: IDLE -> WDATA -> WREQ -> (WDATA | BRESP) -> IDLE; IDLE -> RREQ -> RRESP -> (RREQ | IDLE).
- IDLE: sxawready and sxarready are combinational, and at most one is high. If both AW and AR are valid, serve the opposite of the last-served direction (toggle after each accepted transaction). On accept, latch ID, address, len, and beat counter = len.
- WDATA: sxwready=1. On wvalid, latch wdata and go to WREQ. wlast is not a port; the beat count alone ends the burst.
- WREQ / RREQ: req_valid=1 with address, write, wdata and master_id stable until req_ready. On req_ready, OR req_error into a sticky error bit and set address += BW_DATA/8 (mod 2^BW_ADDR). Go to RREQ/WREQ no earlier than the cycle after the accept; req_valid is never high in the same cycle as an address handshake.
- WREQ exit: if counter==0, go to BRESP; otherwise decrement the counter and go to WDATA.
- BRESP: sxbvalid=1, sxbresp = sticky ? 2'b10 : 2'b00, sxbid = latched ID. On bready, clear sticky and go to IDLE.
- RREQ exit: on req_ready, register sxrdata=req_rdata, sxrresp = req_error ? 2'b10 : 2'b00 (per beat), sxrlast = (counter==0), sxrvalid=1 from the next cycle.
- RRESP: R is held until rready. On rready, go to IDLE if last; otherwise decrement the counter and go to RREQ.
- Throughput: one outstanding transaction; at most one beat in flight.
- len=255 completes 256 beats; the counter never underflows.

Test Plan:
- Single write, awaddr=0x00001000, wdata=0xA5A5A5A5, len=0, req_error=0 -> one req (write=1, addr=0x1000); bresp=00 with bid echoed; exactly one req_valid episode.
- Read burst, len=3, araddr=0x10 -> req_addr 0x10, 0x14, 0x18, 0x1C; four R beats, rlast only on the 4th; rdata equals req_rdata per beat.
- Write burst, len=2, req_error=1 on beat 2 only -> all 3 reqs issued; bresp=10.
- AW and AR asserted in the same cycle twice in a row -> write served first, read second; the other ready stays low while a transaction is in progress.
- rready held low for 5 cycles on beat 0 of a len=1 read -> R stable for 5 cycles; no second req until the handshake.
- rstnn pulsed low during beat 2 of a len=7 read -> all outputs 0 immediately; a new AR is accepted normally after reset release.

Source files
------------

// File: rtl/munoc_control_axi_frontend.sv
// AXI4 slave front end for the MUNOC control register block.
// Each AXI burst is split into single-word register requests, one beat at a
// time; only one transaction and one beat are ever in flight.
module munoc_control_axi_frontend #(
  parameter int BW_ADDR           = 32,
  parameter int BW_DATA           = 32,
  parameter int BW_AXI_TID        = 4,
  parameter int BW_MASTER_NODE_ID = 4
) (
  input  logic                         clk,
  input  logic                         rstnn,
  input  logic [BW_AXI_TID-1:0]        sxawid,
  input  logic [BW_ADDR-1:0]           sxawaddr,
  input  logic [7:0]                   sxawlen,
  input  logic                         sxawvalid,
  output logic                         sxawready,
  input  logic [BW_DATA-1:0]           sxwdata,
  input  logic                         sxwvalid,
  output logic                         sxwready,
  output logic [BW_AXI_TID-1:0]        sxbid,
  output logic [1:0]                   sxbresp,
  output logic                         sxbvalid,
  input  logic                         sxbready,
  input  logic [BW_AXI_TID-1:0]        sxarid,
  input  logic [BW_ADDR-1:0]           sxaraddr,
  input  logic [7:0]                   sxarlen,
  input  logic                         sxarvalid,
  output logic                         sxarready,
  output logic [BW_AXI_TID-1:0]        sxrid,
  output logic [BW_DATA-1:0]           sxrdata,
  output logic [1:0]                   sxrresp,
  output logic                         sxrlast,
  output logic                         sxrvalid,
  input  logic                         sxrready,
  output logic                         req_valid,
  output logic [BW_ADDR-1:0]           req_addr,
  output logic                         req_write,
  output logic [BW_DATA-1:0]           req_wdata,
  output logic [BW_MASTER_NODE_ID-1:0] req_master_id,
  input  logic                         req_ready,
  input  logic [BW_DATA-1:0]           req_rdata,
  input  logic                         req_error
);

  localparam logic [BW_ADDR-1:0] ADDR_STEP = BW_ADDR'(BW_DATA / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WREQ, S_BRESP, S_RREQ, S_RRESP
  } state_t;

  state_t                r_state, w_next;
  logic                  r_prio_wr;   // 1: write wins a simultaneous AW/AR
  logic [BW_AXI_TID-1:0] r_id;
  logic [BW_ADDR-1:0]    r_addr;
  logic [7:0]            r_cnt;       // beats remaining after the current one
  logic [BW_DATA-1:0]    r_wdata;
  logic [BW_DATA-1:0]    r_rdata;
  logic                  r_err;       // sticky unmapped-access flag
  logic                  r_rerr;
  logic                  r_rlast;
  logic                  w_aw_sel;
  logic                  w_ar_sel;

  // Address-channel arbitration: only in IDLE, at most one ready at a time.
  always_comb begin
    w_aw_sel = 1'b0;
    w_ar_sel = 1'b0;
    if (r_state == S_IDLE) begin
      w_aw_sel = sxawvalid && (r_prio_wr || !sxarvalid);
      w_ar_sel = sxarvalid && !w_aw_sel;
    end
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_aw_sel)      w_next = S_WDATA;
        else if (w_ar_sel) w_next = S_RREQ;
      end
      S_WDATA: if (sxwvalid)  w_next = S_WREQ;
      S_WREQ:  if (req_ready) w_next = (r_cnt == 8'd0) ? S_BRESP : S_WDATA;
      S_BRESP: if (sxbready)  w_next = S_IDLE;
      S_RREQ:  if (req_ready) w_next = S_RRESP;
      S_RRESP: if (sxrready)  w_next = r_rlast ? S_IDLE : S_RREQ;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus per-transaction and per-beat bookkeeping.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state   <= S_IDLE;
      r_prio_wr <= 1'b1;
      r_id      <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_rerr    <= 1'b0;
      r_rlast   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_aw_sel) begin
            r_id      <= sxawid;
            r_addr    <= sxawaddr;
            r_cnt     <= sxawlen;
            r_prio_wr <= 1'b0;
            // a read burst may have left the sticky flag set; start writes clean
            r_err     <= 1'b0;
          end else if (w_ar_sel) begin
            r_id      <= sxarid;
            r_addr    <= sxaraddr;
            r_cnt     <= sxarlen;
            r_prio_wr <= 1'b1;
          end
        end
        S_WDATA: if (sxwvalid) r_wdata <= sxwdata;
        S_WREQ: begin
          if (req_ready) begin
            r_err  <= r_err | req_error;
            r_addr <= r_addr + ADDR_STEP;
            if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
          end
        end
        S_BRESP: if (sxbready) r_err <= 1'b0;
        S_RREQ: begin
          if (req_ready) begin
            r_err   <= r_err | req_error;
            r_addr  <= r_addr + ADDR_STEP;
            r_rdata <= req_rdata;
            r_rerr  <= req_error;
            r_rlast <= (r_cnt == 8'd0);
          end
        end
        S_RRESP: if (sxrready && !r_rlast) r_cnt <= r_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  assign sxawready     = w_aw_sel;
  assign sxarready     = w_ar_sel;
  assign sxwready      = (r_state == S_WDATA);
  assign sxbvalid      = (r_state == S_BRESP);
  assign sxbid         = r_id;
  assign sxbresp       = {r_err, 1'b0};
  assign sxrvalid      = (r_state == S_RRESP);
  assign sxrid         = r_id;
  assign sxrdata       = r_rdata;
  assign sxrresp       = {r_rerr, 1'b0};
  assign sxrlast       = r_rlast;
  assign req_valid     = (r_state == S_WREQ) || (r_state == S_RREQ);
  assign req_write     = (r_state == S_WREQ);
  assign req_addr      = r_addr;
  assign req_wdata     = r_wdata;
  assign req_master_id = r_id[BW_AXI_TID-1 -: BW_MASTER_NODE_ID];

endmodule
